trena_ascii_sequencer: RTL and testbench
========================================

# trena_ascii_sequencer

Parametrised measurement-to-serial sequencer for the ultrasonic tape measure. It sits between the HC-SR04 interface and the 7E1 serial transmitter and replaces the fixed 4-way digit mux. It requests a measurement, captures the BCD result, and sends the whole reading as an ASCII message (digits MSD first, then a terminator) over a byte handshake. It adds a continuous mode with a programmable repeat interval and a measurement timeout.

## Interface
- DIGITS, 3: number of BCD digits in `medida`; a message is DIGITS+1 characters.
- TERMINATOR, 7'h23: ASCII character sent after the last digit ('#').
- TIMEOUT, 50_000_000: cycles to wait for `medida_pronto` before flagging an error.
- INTERVAL, 25_000_000: idle cycles between messages in continuous mode.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- mensurar  in  1  start request; sampled only in INICIAL.
- continuo  in  1  continuous mode enable; level.
- medir  out  1  one-cycle measurement request to the sensor interface.
- medida  in  4*DIGITS  BCD measurement; the most significant digit is in the top nibble.
- medida_pronto  in  1  one-cycle pulse; `medida` is valid in the same cycle.
- tx_partida  out  1  one-cycle start pulse to the transmitter.
- tx_dados  out  7  ASCII character for the transmitter; held stable from `tx_partida` until `tx_pronto`.
- tx_pronto  in  1  one-cycle pulse when the transmitter has finished the character.
- pronto  out  1  one-cycle pulse after the terminator has been sent.
- erro  out  1  latched timeout flag.
- db_estado  out  4  current state encoding.

## Operation
- **States and encodings:** INICIAL 0, PREPARA 1, AGUARDA_MEDIDA 2, TRANSMITE 3, AGUARDA_TX 4, FINAL 5, ESPERA_INTERVALO 6, ERRO 4'hF.
- **INICIAL**
  - `mensurar`=1 → PREPARA.
  - Entering PREPARA clears `erro` and the timeout counter.
- **PREPARA:** `medir`=1 for this one cycle, then → AGUARDA_MEDIDA.
- **AGUARDA_MEDIDA:** the timeout counter increments every cycle.
  - `medida_pronto`=1 → capture `medida` into an internal register, set index to 0, load `tx_dados` with char(0), → TRANSMITE.
  - Otherwise, counter reaches TIMEOUT-1 → ERRO.
  - `medida_pronto` takes priority over the timeout in the same cycle.
- **TRANSMITE:** `tx_partida`=1 for one cycle, then → AGUARDA_TX.
- **AGUARDA_TX:** on `tx_pronto`=1:
  - If index=DIGITS → FINAL.
  - Otherwise, index+1 and `tx_dados` = char(index+1), → TRANSMITE.
- **FINAL:** `pronto`=1 for one cycle.
  - `continuo`=1 → ESPERA_INTERVALO with the interval counter cleared.
  - Otherwise → INICIAL.
- **ESPERA_INTERVALO:** the counter increments.
  - `continuo`=0 → INICIAL, taking priority over the count.
  - Counter reaches INTERVAL-1 → PREPARA.
- **ERRO:** sets `erro`=1, then → INICIAL next cycle. `erro` stays high until the next PREPARA entry. Continuous mode does not auto-retry after an error.
- **Character mapping**
  - For i < DIGITS: char(i) = 7'h30 + digit, where the digit is the nibble (DIGITS-1-i), MSD first.
  - A nibble > 9 maps to 7'h3F ('?').
  - char(DIGITS) = TERMINATOR.
- **Inputs ignored by state**
  - `mensurar` is ignored outside INICIAL.
  - `medida_pronto` is ignored outside AGUARDA_MEDIDA.
  - `tx_pronto` is ignored outside AGUARDA_TX.
- **Capture:** the captured value is used for the whole message. Later changes on `medida` do not affect it.
- **Counter widths:** sized with $clog2 of TIMEOUT and INTERVAL. The index is $clog2(DIGITS+1) bits.

## Timing
- **Reset:** asynchronous. All outputs are 0, `tx_dados`=7'h00, `db_estado`=0, all counters, index and capture register are 0, state is INICIAL. Reset mid-message aborts it immediately; no further `tx_partida` pulses are issued.
- **Outputs:** all outputs are registered or Moore-decoded from state; no combinational path from inputs to outputs.
- **Start:** `mensurar` high on edge k gives `medir`=1 in cycle k+1.
- **Capture to first character:** `medida_pronto` on edge m gives `tx_partida`=1 in cycle m+1, with `tx_dados` already valid in that cycle.
- **Next character:** `tx_pronto` on edge t gives the next `tx_partida` in cycle t+1, or `pronto` in cycle t+1 after the terminator.
- **Continuous mode:** `pronto` at cycle p gives the next `medir` at cycle p+1+INTERVAL.
- **Timeout:** with no response, `medir` at cycle r gives ERRO at cycle r+1+TIMEOUT and `erro`=1 from cycle r+2+TIMEOUT.

## Test plan
- Single shot, DIGITS=3, `medida`=12'h147:
  - One `medir` pulse.
  - Characters 7'h31, 7'h34, 7'h37, 7'h23, each with one `tx_partida`.
  - `pronto` once, back to `db_estado`=0.
- Invalid BCD, `medida`=12'h0A5 → characters 7'h30, 7'h3F, 7'h35, 7'h23.
- Timeout, TIMEOUT=50, no `medida_pronto`:
  - `db_estado`=F for one cycle, then `erro`=1 held and `db_estado`=0.
  - A new `mensurar` clears `erro` in the PREPARA cycle.
- Continuous mode, INTERVAL=20, `continuo`=1:
  - Two complete messages with exactly 21 cycles from `pronto` to the next `medir`.
  - Dropping `continuo` mid-interval → INICIAL, no further `medir`.
- Capture stability: change `medida` to 12'h999 during AGUARDA_TX after capturing 12'h123 → message still 7'h31, 7'h32, 7'h33, 7'h23.
- Reset during the second character → all outputs 0 in the same cycle, no further `tx_partida`. `mensurar` and `tx_pronto` pulses in INICIAL before the restart cause nothing.

Source files
------------

// File: rtl/trena_ascii_sequencer.sv
// Measurement-to-serial sequencer: requests a reading, captures the BCD result and
// streams it as ASCII digits (MSD first) plus a terminator over a byte handshake.
module trena_ascii_sequencer #(
  parameter int         DIGITS     = 3,
  parameter logic [6:0] TERMINATOR = 7'h23,
  parameter int         TIMEOUT    = 50_000_000,
  parameter int         INTERVAL   = 25_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mensurar,
  input  logic                continuo,
  output logic                medir,
  input  logic [4*DIGITS-1:0] medida,
  input  logic                medida_pronto,
  output logic                tx_partida,
  output logic [6:0]          tx_dados,
  input  logic                tx_pronto,
  output logic                pronto,
  output logic                erro,
  output logic [3:0]          db_estado
);

  localparam int TMO_W = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
  localparam int IVL_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int IDX_W = $clog2(DIGITS + 1);

  typedef enum logic [3:0] {
    INICIAL          = 4'h0,
    PREPARA          = 4'h1,
    AGUARDA_MEDIDA   = 4'h2,
    TRANSMITE        = 4'h3,
    AGUARDA_TX       = 4'h4,
    FINAL            = 4'h5,
    ESPERA_INTERVALO = 4'h6,
    ERRO             = 4'hF
  } state_t;

  state_t              state, nxt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [IVL_W-1:0]    ivl_cnt;
  logic [IDX_W-1:0]    idx, idx_inc;
  logic [4*DIGITS-1:0] cap;
  logic [DIGITS:0][6:0] chr_cap;
  logic                last_chr;

  function automatic logic [6:0] bcd_char(input logic [3:0] nib);
    return (nib > 4'd9) ? 7'h3F : 7'h30 + {3'b000, nib};
  endfunction

  // One ASCII lane per captured digit, MSD in lane 0; the last lane is the terminator
  for (genvar g = 0; g < DIGITS; g++) begin : g_chr
    assign chr_cap[g] = bcd_char(cap[4*(DIGITS-1-g) +: 4]);
  end
  assign chr_cap[DIGITS] = TERMINATOR;

  assign idx_inc  = idx + IDX_W'(1);
  assign last_chr = (idx == IDX_W'(DIGITS));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INICIAL;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      INICIAL:          if (mensurar) nxt = PREPARA;
      PREPARA:          nxt = AGUARDA_MEDIDA;
      AGUARDA_MEDIDA: begin
        if (medida_pronto)                      nxt = TRANSMITE;
        else if (tmo_cnt == TMO_W'(TIMEOUT-1))  nxt = ERRO;
      end
      TRANSMITE:        nxt = AGUARDA_TX;
      AGUARDA_TX:       if (tx_pronto) nxt = last_chr ? FINAL : TRANSMITE;
      FINAL:            nxt = continuo ? ESPERA_INTERVALO : INICIAL;
      ESPERA_INTERVALO: begin
        if (!continuo)                          nxt = INICIAL;
        else if (ivl_cnt == IVL_W'(INTERVAL-1)) nxt = PREPARA;
      end
      ERRO:             nxt = INICIAL;
      default:          nxt = INICIAL;
    endcase
  end

  always_comb begin
    medir      = (state == PREPARA);
    tx_partida = (state == TRANSMITE);
    pronto     = (state == FINAL);
    db_estado  = state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt  <= '0;
      ivl_cnt  <= '0;
      idx      <= '0;
      cap      <= '0;
      tx_dados <= 7'h00;
      erro     <= 1'b0;
    end else begin
      // PREPARA is only ever entered from another state, so this fires once per entry
      if (nxt == PREPARA)                 tmo_cnt <= '0;
      else if (state == AGUARDA_MEDIDA)   tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (nxt == PREPARA)                 erro <= 1'b0;
      else if (state == ERRO)             erro <= 1'b1;

      if (state == FINAL)                 ivl_cnt <= '0;
      else if (state == ESPERA_INTERVALO) ivl_cnt <= ivl_cnt + IVL_W'(1);

      if (state == AGUARDA_MEDIDA && medida_pronto) begin
        cap      <= medida;
        idx      <= '0;
        tx_dados <= bcd_char(medida[4*DIGITS-1 -: 4]);
      end else if (state == AGUARDA_TX && tx_pronto && !last_chr) begin
        idx      <= idx_inc;
        tx_dados <= chr_cap[idx_inc];
      end
    end
  end

endmodule

// File: tb/tb_trena_ascii_sequencer.sv
// Self-checking bench: vector table, corner-case sequences and randomized messages
// checked against a digit-arithmetic reference model.
module tb_trena_ascii_sequencer;
  localparam int DIGITS   = 3;
  localparam int TIMEOUT  = 50;
  localparam int INTERVAL = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mensurar = 1'b0, continuo = 1'b0, medida_pronto = 1'b0, tx_pronto = 1'b0;
  logic [11:0] medida = '0;
  logic        medir, tx_partida, pronto, erro;
  logic [6:0]  tx_dados;
  logic [3:0]  db_estado;

  trena_ascii_sequencer #(
    .DIGITS(DIGITS), .TERMINATOR(7'h23), .TIMEOUT(TIMEOUT), .INTERVAL(INTERVAL)
  ) dut (
    .clock(clock), .reset(reset), .mensurar(mensurar), .continuo(continuo),
    .medir(medir), .medida(medida), .medida_pronto(medida_pronto),
    .tx_partida(tx_partida), .tx_dados(tx_dados), .tx_pronto(tx_pronto),
    .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0]     medida;
    int              rdelay;
    int              txdelay;
    bit              scramble;
    logic [3:0][6:0] chars;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int n_medir = 0, n_tx = 0, n_pronto = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are stable at the falling edge; inputs are changed right after sampling.
  task automatic tick();
    @(negedge clock);
    n_medir  += int'(medir);
    n_tx     += int'(tx_partida);
    n_pronto += int'(pronto);
  endtask

  function automatic logic [6:0] model_char(input int v, input int i);
    int d;
    if (i == DIGITS) return 7'h23;
    d = (v / (1 << (4 * (DIGITS - 1 - i)))) % 16;
    return (d > 9) ? 7'h3F : 7'(48 + d);
  endfunction

  task automatic start_meas();
    mensurar = 1'b1;
    tick();
    mensurar = 1'b0;
    check("start_medir", medir, 1);
    check("start_state", db_estado, 4'h1);
  endtask

  // Entered in the PREPARA cycle; returns in the cycle where pronto should be high.
  task automatic finish_msg(input logic [11:0] val, input logic [3:0][6:0] exp,
                            input int rdelay, input int txdelay, input bit scramble);
    medida = 12'($urandom);
    tick();
    repeat (rdelay) tick();
    medida = val;
    medida_pronto = 1'b1;
    tick();
    medida_pronto = 1'b0;
    for (int i = 0; i <= DIGITS; i++) begin
      check($sformatf("partida_%0d", i), tx_partida, 1);
      check($sformatf("char_%0d", i), tx_dados, exp[i]);
      tick();
      if (scramble) begin
        medida   = 12'h999;
        mensurar = 1'b1;
      end
      repeat (txdelay) tick();
      check($sformatf("hold_%0d", i), tx_dados, exp[i]);
      mensurar  = 1'b0;
      tx_pronto = 1'b1;
      tick();
      tx_pronto = 1'b0;
    end
    check("pronto", pronto, 1);
  endtask

  task automatic run_single(input vec_t v);
    int b_m, b_t, b_p;
    b_m = n_medir; b_t = n_tx; b_p = n_pronto;
    start_meas();
    finish_msg(v.medida, v.chars, v.rdelay, v.txdelay, v.scramble);
    tick();
    check("back_idle", db_estado, 4'h0);
    check("n_medir", n_medir - b_m, 1);
    check("n_partida", n_tx - b_t, DIGITS + 1);
    check("n_pronto", n_pronto - b_p, 1);
  endtask

  initial begin
    vec_t vecs[5];
    logic [3:0][6:0] exp;
    int found, j, base;
    logic [11:0] rv;

    vecs[0] = '{medida: 12'h147, rdelay: 0,  txdelay: 0, scramble: 1'b0, chars: {7'h23, 7'h37, 7'h34, 7'h31}};
    vecs[1] = '{medida: 12'h0A5, rdelay: 3,  txdelay: 2, scramble: 1'b0, chars: {7'h23, 7'h35, 7'h3F, 7'h30}};
    vecs[2] = '{medida: 12'h123, rdelay: 1,  txdelay: 1, scramble: 1'b1, chars: {7'h23, 7'h33, 7'h32, 7'h31}};
    vecs[3] = '{medida: 12'hFFF, rdelay: TIMEOUT-1, txdelay: 0, scramble: 1'b0, chars: {7'h23, 7'h3F, 7'h3F, 7'h3F}};
    vecs[4] = '{medida: 12'h909, rdelay: 2,  txdelay: 4, scramble: 1'b1, chars: {7'h23, 7'h39, 7'h30, 7'h39}};

    // Reset state
    repeat (2) tick();
    check("reset_outs", {medir, tx_partida, tx_dados, pronto, erro, db_estado}, 0);
    reset = 1'b0;
    tick();
    check("post_reset_state", db_estado, 4'h0);

    foreach (vecs[k]) run_single(vecs[k]);

    // Continuous mode: exact interval between messages, then drop continuo mid-interval
    continuo = 1'b1;
    start_meas();
    finish_msg(12'h258, {7'h23, 7'h38, 7'h35, 7'h32}, 2, 1, 1'b0);
    found = 0; j = 0;
    while (found == 0 && j < 40) begin
      tick(); j++;
      if (medir) found = j;
    end
    check("interval_cycles", found, INTERVAL + 1);
    finish_msg(12'h369, {7'h23, 7'h39, 7'h36, 7'h33}, 0, 0, 1'b0);
    repeat (5) tick();
    check("espera_state", db_estado, 4'h6);
    continuo = 1'b0;
    tick();
    check("cont_drop_idle", db_estado, 4'h0);
    base = n_medir;
    repeat (40) tick();
    check("cont_drop_no_medir", n_medir - base, 0);

    // Timeout with continuo high: no auto-retry
    continuo = 1'b1;
    start_meas();
    repeat (TIMEOUT) tick();
    check("tmo_still_waiting", db_estado, 4'h2);
    tick();
    check("tmo_erro_state", db_estado, 4'hF);
    check("tmo_erro_not_yet", erro, 0);
    tick();
    check("tmo_erro_set", erro, 1);
    check("tmo_back_idle", db_estado, 4'h0);
    base = n_medir;
    repeat (10) tick();
    check("tmo_erro_held", erro, 1);
    check("tmo_no_retry", n_medir - base, 0);
    continuo = 1'b0;
    start_meas();
    check("erro_cleared", erro, 0);
    finish_msg(12'h147, vecs[0].chars, 0, 0, 1'b0);
    tick();
    check("after_tmo_idle", db_estado, 4'h0);

    // Reset during the second character
    start_meas();
    tick();
    medida = 12'h123; medida_pronto = 1'b1;
    tick();
    medida_pronto = 1'b0;
    tick();
    tx_pronto = 1'b1;
    tick();
    tx_pronto = 1'b0;
    check("second_char", tx_dados, 7'h32);
    #2 reset = 1'b1;
    #1 check("async_reset_outs", {medir, tx_partida, tx_dados, pronto, erro, db_estado}, 0);
    tick();
    reset = 1'b0;
    base = n_tx;
    tx_pronto = 1'b1; tick(); tx_pronto = 1'b0;
    medida_pronto = 1'b1; tick(); medida_pronto = 1'b0;
    repeat (10) tick();
    check("reset_no_partida", n_tx - base, 0);
    check("reset_idle", db_estado, 4'h0);
    run_single(vecs[0]);

    // Randomized messages against the reference model
    for (int r = 0; r < 25; r++) begin
      vec_t v;
      rv = 12'($urandom_range(0, 4095));
      for (int i = 0; i <= DIGITS; i++) exp[i] = model_char(int'(rv), i);
      v = '{medida: rv, rdelay: int'($urandom_range(0, TIMEOUT-1)),
            txdelay: int'($urandom_range(0, 5)), scramble: 1'b1, chars: exp};
      run_single(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
